// File: rtl/simd_pkg.sv
// Shared SIMD definitions: opcode field, HALT encoding and sequencer state enum.
package simd_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/simd_sequencer.sv
// SIMD program sequencer: fetch, slot-paced issue with stall, HALT drain.
// Performance counters are built only when SIMD_SEQ_PERF_EN is defined.
module simd_sequencer
  import simd_pkg::*;
#(
  parameter int unsigned INS_ADDR_WIDTH = 8,
  parameter int unsigned ISSUE_PERIOD   = 2,
  parameter int unsigned PIPE_DEPTH     = 3,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic                      stall,
  input  logic [OPCODE_WIDTH-1:0]   ins_opcode,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic                      ins_en,
  output logic                      issue,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      issued_count,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam int unsigned PHASE_W   = (ISSUE_PERIOD > 1) ? $clog2(ISSUE_PERIOD) : 1;
  localparam int unsigned DRAIN_CYC = PIPE_DEPTH * ISSUE_PERIOD;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);

  seq_state_e                r_state;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic [PHASE_W-1:0]        r_phase;
  logic [DRAIN_W-1:0]        r_drain;
  logic                      r_ins_en;
  logic                      r_issue;
  logic                      r_busy;
  logic                      r_done;

  logic [PHASE_W-1:0]        w_phase_next;
  logic                      w_slot;
  logic                      w_halt;

  assign w_phase_next = (r_phase == PHASE_W'(ISSUE_PERIOD - 1)) ? '0 : r_phase + PHASE_W'(1);
  assign w_slot       = (r_state == RUN) && (r_phase == '0);
  assign w_halt       = (ins_opcode == OP_HALT);

  // HALT is checked before stall so a stalled HALT still drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_phase  <= '0;
      r_drain  <= '0;
      r_ins_en <= 1'b0;
      r_issue  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FETCH;
            r_pc     <= start_pc;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_ins_en <= 1'b1;
          end
        end
        FETCH: begin
          r_phase <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_phase == '0) begin
            if (w_halt) begin
              r_drain  <= DRAIN_W'(DRAIN_CYC);
              r_ins_en <= 1'b0;
              r_state  <= DRAIN;
            end else if (!stall) begin
              r_issue <= 1'b1;
              r_pc    <= r_pc + INS_ADDR_WIDTH'(1);
              r_phase <= w_phase_next;
            end
          end else begin
            r_phase <= w_phase_next;
          end
        end
        DRAIN: begin
          if (r_drain == DRAIN_W'(1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_drain <= r_drain - DRAIN_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc     = r_pc;
  assign ins_en = r_ins_en;
  assign issue  = r_issue;
  assign busy   = r_busy;
  assign done   = r_done;

`ifdef SIMD_SEQ_PERF_EN
  logic w_cnt_clr;
  logic w_issue_inc;
  logic w_stall_inc;

  assign w_cnt_clr   = (r_state == IDLE) && start;
  assign w_issue_inc = w_slot && !w_halt && !stall;
  assign w_stall_inc = (r_state == RUN) && stall;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_issued_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_issue_inc),
    .o_count (issued_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_stall_inc),
    .o_count (stall_count)
  );
`else
  logic w_unused_slot;
  assign w_unused_slot = w_slot;
  assign issued_count  = '0;
  assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_simd_sequencer.sv
// Bench for simd_sequencer: BRAM model, slot-level reference model, directed programs.
module tb_simd_sequencer;
  import simd_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned IP = 2;
  localparam int unsigned PD = 3;
  localparam int unsigned CW = 16;
`ifdef SIMD_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    stall = 1'b0;
  logic [AW-1:0]           start_pc = '0;
  logic [OPCODE_WIDTH-1:0] ins_opcode = '0;
  logic [AW-1:0]           pc;
  logic                    ins_en, issue, busy, done;
  logic [CW-1:0]           issued_count, stall_count;

  logic [OPCODE_WIDTH-1:0] mem [256];

  always #5 clk = ~clk;

  simd_sequencer #(
    .INS_ADDR_WIDTH (AW),
    .ISSUE_PERIOD   (IP),
    .PIPE_DEPTH     (PD),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_pc     (start_pc),
    .stall        (stall),
    .ins_opcode   (ins_opcode),
    .pc           (pc),
    .ins_en       (ins_en),
    .issue        (issue),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count),
    .stall_count  (stall_count)
  );

  // Instruction BRAM: one-cycle read latency.
  always @(posedge clk) if (ins_en) ins_opcode <= mem[pc];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: counts edges to the next slot decision, then counts down the drain.
  int            m_mode  = 0;
  int            m_until = 0;
  int            m_drain = 0;
  bit            m_fetch = 1'b0;
  logic [AW-1:0] m_pc = '0;
  logic          m_issue = 1'b0, m_ins_en = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [CW-1:0] m_ic = '0, m_sc = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = '0; m_issue = 1'b0; m_ins_en = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_ic = '0; m_sc = '0;
    end else begin
      m_issue = 1'b0;
      if (m_mode == 0) begin
        if (start) begin
          m_mode = 1; m_busy = 1'b1; m_done = 1'b0; m_pc = start_pc;
          m_ic = '0; m_sc = '0; m_ins_en = 1'b1; m_until = 2; m_fetch = 1'b1;
        end
      end else if (m_mode == 1) begin
        if (!m_fetch && stall && m_sc != '1) m_sc = m_sc + 1'b1;
        m_fetch = 1'b0;
        m_until--;
        if (m_until == 0) begin
          if (mem[m_pc] == OP_HALT) begin
            m_mode = 2; m_drain = PD * IP; m_ins_en = 1'b0;
          end else if (stall) begin
            m_until = 1;
          end else begin
            m_issue = 1'b1; m_pc = m_pc + 1'b1; m_until = IP;
            if (m_ic != '1) m_ic = m_ic + 1'b1;
          end
        end
      end else begin
        m_drain--;
        if (m_drain == 0) begin
          m_mode = 0; m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ins_en", 32'(ins_en), 32'(m_ins_en));
      chk("issue", 32'(issue), 32'(m_issue));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("issued_count", 32'(issued_count), PERF ? 32'(m_ic) : 32'd0);
      chk("stall_count", 32'(stall_count), PERF ? 32'(m_sc) : 32'd0);
    end
  end

  int iss_q[$];
  int done_cyc = 0;
  int s_cyc = 0;
  logic r_done_d = 1'b0;

  always @(negedge clk) begin
    if (issue === 1'b1) iss_q.push_back(cyc);
    if (done === 1'b1 && r_done_d !== 1'b1) done_cyc = cyc;
    r_done_d = done;
  end

  task automatic launch(input logic [AW-1:0] addr);
    @(negedge clk);
    start_pc = addr;
    start = 1'b1;
    iss_q.delete();
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_to(input int k);
    int guard = 0;
    while (cyc < s_cyc + k && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= bound) begin
      n_err++;
      $display("FAIL %s: busy still 0x%0h after %0d cycles, expected 0", name, busy, bound);
    end
    @(negedge clk);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'h1;
    mem[8'h10] = 4'h1; mem[8'h11] = 4'h2; mem[8'h12] = 4'h3; mem[8'h13] = OP_HALT;
    mem[8'h23] = OP_HALT;
    mem[8'hFF] = 4'h5; mem[8'h00] = OP_HALT;
    mem[8'h31] = OP_HALT;

    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ins_en", 32'(ins_en), 32'h0);
    rst = 1'b0;

    // Three ordinary instructions then HALT at 0x10.
    launch(8'h10);
    wait_idle("s1_finish", 40);
    chk("s1_nissue", 32'(iss_q.size()), 32'd3);
    if (iss_q.size() >= 3) begin
      chk("s1_issue0", 32'(iss_q[0] - s_cyc), 32'd2);
      chk("s1_issue1", 32'(iss_q[1] - s_cyc), 32'd4);
      chk("s1_issue2", 32'(iss_q[2] - s_cyc), 32'd6);
    end
    chk("s1_pc", 32'(pc), 32'h13);
    chk("s1_done_lat", 32'(done_cyc - s_cyc), 32'd14);
    chk("s1_icount", 32'(issued_count), PERF ? 32'd3 : 32'd0);
    chk("s1_scount", 32'(stall_count), 32'd0);

    // Five-cycle stall across the second slot decision.
    launch(8'h20);
    wait_to(3);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("s2_pc_frozen", 32'(pc), 32'h21);
    repeat (2) @(negedge clk);
    stall = 1'b0;
    wait_idle("s2_finish", 40);
    chk("s2_nissue", 32'(iss_q.size()), 32'd3);
    if (iss_q.size() >= 2) chk("s2_issue1", 32'(iss_q[1] - s_cyc), 32'd9);
    chk("s2_scount", 32'(stall_count), PERF ? 32'd5 : 32'd0);
    chk("s2_done", 32'(done), 32'h1);

    // pc wrap from 0xFF into the HALT at 0x00.
    launch(8'hFF);
    wait_to(2);
    chk("s3_pc_wrap", 32'(pc), 32'h00);
    wait_idle("s3_finish", 40);
    chk("s3_icount", 32'(issued_count), PERF ? 32'd1 : 32'd0);

    // Start pulses ignored while busy and on the done edge, accepted one cycle later.
    launch(8'h10);
    wait_to(2);
    start_pc = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_pc = 8'h10;
    wait_to(9);
    start_pc = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_pc = 8'h10;
    wait_to(13);
    start = 1'b1;
    @(negedge clk);
    chk("s4_done_edge", 32'(done), 32'h1);
    chk("s4_busy_edge", 32'(busy), 32'h0);
    chk("s4_pc_edge", 32'(pc), 32'h13);
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
    chk("s4_done_clr", 32'(done), 32'h0);
    chk("s4_busy_again", 32'(busy), 32'h1);
    chk("s4_pc_restart", 32'(pc), 32'h10);
    wait_idle("s4_finish", 40);
    chk("s4_icount", 32'(issued_count), PERF ? 32'd3 : 32'd0);

    // Reset in the middle of a slot.
    launch(8'h10);
    wait_to(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_pc", 32'(pc), 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    chk("s5_ins_en", 32'(ins_en), 32'h0);
    chk("s5_issue", 32'(issue), 32'h0);
    chk("s5_icount", 32'(issued_count), 32'h0);
    repeat (12) @(negedge clk);
    chk("s5_no_done", 32'(done), 32'h0);

    // Long stall saturates the stall counter.
    launch(8'h30);
    wait_to(1);
    stall = 1'b1;
    repeat (65540) @(negedge clk);
    stall = 1'b0;
    wait_idle("s6_finish", 40);
    chk("s6_scount_sat", 32'(stall_count), PERF ? 32'h0000FFFF : 32'd0);
    chk("s6_icount", 32'(issued_count), PERF ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simd_sequencer.md
# simd_sequencer

Program sequencer for the SIMD datapath. Accepts a start request from the host, fetches instructions from the instruction BRAM, and drives the program counter. Emits one issue strobe per datapath slot, honouring `stall`. On a HALT opcode it drains the three-stage load/execute/store pipeline, then reports completion.

## Interface
- `INS_ADDR_WIDTH`, 8, instruction BRAM address width (width of `pc`)
- `OPCODE_WIDTH`, from `simd_pkg`, opcode field width
- `ISSUE_PERIOD`, 2, clocks per datapath slot (datapath advances at half rate)
- `PIPE_DEPTH`, 3, datapath stages after issue (load, execute, store)
- `CNT_WIDTH`, 16, width of performance counters
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock domain; synchronous, active-high
- `start`  in  1  host start request, sampled only when not busy
- `start_pc`  in  INS_ADDR_WIDTH  first instruction address, captured with `start`
- `stall`  in  1  hold issue; pc and slot phase frozen while high
- `ins_opcode`  in  OPCODE_WIDTH  opcode field of instruction BRAM read data (1-cycle read latency)
- `pc`  out  INS_ADDR_WIDTH  instruction BRAM address
- `ins_en`  out  1  instruction BRAM read enable
- `issue`  out  1  one-cycle strobe: datapath captures decoded control and advances its pipeline
- `busy`  out  1  high from start acceptance until drain completes
- `done`  out  1  level; set when drain completes, cleared on next accepted start
- `issued_count`  out  CNT_WIDTH  instructions issued in current run
- `stall_count`  out  CNT_WIDTH  RUN-state cycles with `stall` high

## Operation
- States: IDLE, FETCH, RUN, DRAIN. The `rst` state is IDLE.
- IDLE:
  - `start`=1 → `pc`<=`start_pc`, `done`<=0, counters<=0, go to FETCH.
  - `start` is ignored in every other state.
- FETCH: one cycle covering BRAM read latency; `phase`<=0; go to RUN.
- RUN: `phase` counts 0..ISSUE_PERIOD-1. At `phase`=0:
  - `stall`=1 → no issue; `phase` and `pc` held; `stall_count`+1.
  - `ins_opcode`==`OP_HALT` → no issue; `drain_cnt`<=PIPE_DEPTH*ISSUE_PERIOD; go to DRAIN.
  - Otherwise → `issue`=1, `pc`<=`pc`+1, `issued_count`+1.
  - HALT takes priority over `stall`.
- DRAIN: `drain_cnt` decrements every cycle regardless of `stall`. At 1 → `done`<=1, go to IDLE.
- `pc` increments modulo 2^INS_ADDR_WIDTH; it wraps from max to 0 silently.
- Counters saturate at all-ones.
- `ins_en`=1 in FETCH and RUN, 0 otherwise.
- `busy`=1 in FETCH, RUN and DRAIN.

## Timing
- Reset values: `pc`=0, `ins_en`=0, `issue`=0, `busy`=0, `done`=0, counters=0.
- `rst` mid-run aborts the run: the next cycle is IDLE with all outputs at reset values; no partial drain.
- All outputs are registered or decoded from state/phase only; no combinational path from `start` or `stall`.
- Latency from `start` edge to first `issue`: 2 cycles (FETCH, then RUN `phase`=0).
- Issue cadence without stall: one strobe every ISSUE_PERIOD cycles.
- `pc` updates on the issue edge. The next opcode is valid ISSUE_PERIOD-1 cycles later, so ISSUE_PERIOD≥2 is required.
- `stall` asserted in a non-zero phase: the slot completes, and the stall takes effect at the next `phase`=0.
- HALT seen at cycle t → `done`=1 and `busy`=0 at t+1+PIPE_DEPTH*ISSUE_PERIOD.
- `start` asserted in the same cycle `done` rises is ignored, because the state is still DRAIN.

## Configuration
- `SIMD_SEQ_PERF_EN` defined: `issued_count` and `stall_count` are live as described above.
- `SIMD_SEQ_PERF_EN` undefined: counter registers are not built and both ports are tied to 0. All other behaviour is identical.

## Structure
- `simd_pkg` holds `OPCODE_WIDTH`, `OP_HALT` (all-ones opcode), and the `seq_state_e` enum (IDLE, FETCH, RUN, DRAIN).
- The same package is shared with the decoder and datapath.
- One sub-module, `sat_counter`, with clear, increment and CNT_WIDTH saturation. It is instantiated twice under the macro.
- FSM, `phase` counter and `drain_cnt` stay in the top module.

## Test plan
- Three ordinary instructions then HALT at `start_pc`=0x10, no stall:
  - `issue` pulses at cycles 2, 4, 6 after start; `pc` ends at 0x13.
  - `done` rises 7 cycles after HALT is seen; `issued_count`=3.
- `stall` held for 5 cycles across `phase`=0 of the second instruction:
  - `pc` frozen; issue gap of 5 cycles plus slot completion.
  - `stall_count`=5; the program still completes.
- `start_pc`=0xFF followed by one ordinary instruction:
  - `pc` wraps to 0x00 after issue; the HALT at 0x00 ends the run.
- `start` pulsed during RUN and DRAIN: ignored, no change to `pc`.
  - `start` one cycle after `done`: accepted, `done` cleared.
- `rst` asserted in RUN mid-slot: next cycle all outputs at reset values, and no `done`.
- Build without `SIMD_SEQ_PERF_EN`: both count ports read 0 throughout the first scenario, and the issue timing is unchanged.
